tb_video_monitor: RTL and testbench

Test-board video monitor sitting directly downstream of the `neogeo` top in the simulation bench. It consumes the composite `VIDEO_SYNC` and 7-bit `VIDEO_R/G/B` outputs, recovers line and frame timing, and produces pixel coordinates. It also produces a per-frame CRC of the visible area, so regressions in the fix/sprite paths can be checked against golden values without dumping frames. It is synthesizable and can also be placed in the test-board CPLD/FPGA.

---
 rtl/tb_video_pkg.sv | 23 ++
 rtl/crc16_ccitt_w21.sv | 24 ++
 rtl/tb_video_monitor.sv | 152 +++++++++++++++
 tb/tb_tb_video_monitor.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_video_pkg.sv
// Shared types and constants for the test-board video monitor.
package tb_video_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } lock_state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  localparam int DEF_LINE_CLKS = 1536;
  localparam int DEF_LINE_TOL  = 8;
  localparam int DEF_HSYNC_MAX = 256;
  localparam int DEF_VSYNC_MIN = 768;
  localparam int DEF_LINES     = 264;
  localparam int DEF_ACT_X0    = 28;
  localparam int DEF_ACT_W     = 320;
  localparam int DEF_ACT_Y0    = 16;
  localparam int DEF_ACT_H     = 224;

endpackage

// File: rtl/crc16_ccitt_w21.sv
// CRC-16-CCITT next state for a 21-bit word, shifted in MSB first in one cycle.
module crc16_ccitt_w21
  import tb_video_pkg::*;
(
  input  logic [20:0] data,
  input  logic [15:0] crc_in,
  output logic [15:0] crc_out
);

  logic [15:0] acc;

  always_comb begin
    acc = crc_in;
    for (int i = 20; i >= 0; i--) begin
      if (acc[15] ^ data[i]) begin
        acc = {acc[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        acc = {acc[14:0], 1'b0};
      end
    end
    crc_out = acc;
  end

endmodule

// File: rtl/tb_video_monitor.sv
// Composite-sync video monitor: recovers line/frame timing from VIDEO_SYNC,
// reports pixel coordinates and a CRC of each frame's visible area.
module tb_video_monitor
  import tb_video_pkg::*;
#(
  parameter int LINE_CLKS = DEF_LINE_CLKS,
  parameter int LINE_TOL  = DEF_LINE_TOL,
  parameter int HSYNC_MAX = DEF_HSYNC_MAX,
  parameter int VSYNC_MIN = DEF_VSYNC_MIN,
  parameter int LINES     = DEF_LINES,
  parameter int ACT_X0    = DEF_ACT_X0,
  parameter int ACT_W     = DEF_ACT_W,
  parameter int ACT_Y0    = DEF_ACT_Y0,
  parameter int ACT_H     = DEF_ACT_H
) (
  input  logic        CLK_24M,
  input  logic        RESET,
  input  logic        VIDEO_SYNC,
  input  logic [6:0]  VIDEO_R,
  input  logic [6:0]  VIDEO_G,
  input  logic [6:0]  VIDEO_B,
  output logic [8:0]  PIX_X,
  output logic [8:0]  PIX_Y,
  output logic        PIX_VALID,
  output logic        FRAME_DONE,
  output logic [15:0] FRAME_CRC,
  output logic [16:0] PIX_COUNT,
  output logic        LOCKED,
  output logic        SYNC_ERR
);

  lock_state_t state_reg;
  logic        sync_q;
  logic [10:0] line_cnt_reg;
  logic [10:0] low_cnt_reg;
  logic        have_edge_reg;
  logic        last_vsync_reg;
  logic [8:0]  pix_y_reg;
  logic [15:0] crc_run_reg;
  logic [16:0] pix_cnt_run_reg;
  logic [15:0] frame_crc_reg;
  logic [16:0] pix_count_reg;
  logic        frame_done_reg;
  logic        sync_err_reg;
  logic [15:0] crc_next;

  logic fall, rise, is_hsync_w, is_vsync_w, width_err, len_err, timeout;
  logic frame_start, count_ok, x_act, y_act, pix_valid;

  assign fall        = sync_q & ~VIDEO_SYNC;
  assign rise        = ~sync_q & VIDEO_SYNC;
  assign is_hsync_w  = low_cnt_reg < 11'(HSYNC_MAX);
  assign is_vsync_w  = low_cnt_reg >= 11'(VSYNC_MIN);
  assign width_err   = rise & ~is_hsync_w & ~is_vsync_w;
  assign frame_start = rise & is_vsync_w & ~last_vsync_reg;
  assign count_ok    = pix_y_reg == 9'(LINES);

  // Line length is line_cnt+1 at the falling edge that ends the line.
  assign len_err = fall & have_edge_reg &
                   ((line_cnt_reg < 11'(LINE_CLKS - LINE_TOL - 1)) ||
                    (line_cnt_reg > 11'(LINE_CLKS + LINE_TOL - 1)));
  assign timeout = have_edge_reg & ~fall & (line_cnt_reg == 11'(LINE_CLKS + LINE_TOL));

  assign x_act = (line_cnt_reg[10:2] >= 9'(ACT_X0)) && (line_cnt_reg[10:2] < 9'(ACT_X0 + ACT_W));
  assign y_act = (pix_y_reg >= 9'(ACT_Y0)) && (pix_y_reg < 9'(ACT_Y0 + ACT_H));
  assign pix_valid = (state_reg == ST_LOCKED) && (line_cnt_reg[1:0] == 2'd2) && x_act && y_act;

  crc16_ccitt_w21 u_crc (
    .data    ({VIDEO_R, VIDEO_G, VIDEO_B}),
    .crc_in  (crc_run_reg),
    .crc_out (crc_next)
  );

  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      state_reg       <= ST_HUNT;
      sync_q          <= 1'b1;
      line_cnt_reg    <= '0;
      low_cnt_reg     <= '0;
      have_edge_reg   <= 1'b0;
      last_vsync_reg  <= 1'b0;
      pix_y_reg       <= '0;
      crc_run_reg     <= CRC_INIT;
      pix_cnt_run_reg <= '0;
      frame_crc_reg   <= '0;
      pix_count_reg   <= '0;
      frame_done_reg  <= 1'b0;
      sync_err_reg    <= 1'b0;
    end else begin
      sync_q         <= VIDEO_SYNC;
      frame_done_reg <= 1'b0;
      sync_err_reg   <= 1'b0;

      if (fall) line_cnt_reg <= '0;
      else if (line_cnt_reg != '1) line_cnt_reg <= line_cnt_reg + 11'd1;

      if (fall) low_cnt_reg <= 11'd1;
      else if (!VIDEO_SYNC && low_cnt_reg != '1) low_cnt_reg <= low_cnt_reg + 11'd1;

      if (rise) last_vsync_reg <= is_vsync_w;
      if (fall) have_edge_reg <= 1'b1;

      if (frame_start) pix_y_reg <= '0;
      else if (fall && pix_y_reg != '1) pix_y_reg <= pix_y_reg + 9'd1;

      if (frame_start) begin
        crc_run_reg     <= CRC_INIT;
        pix_cnt_run_reg <= '0;
      end else if (pix_valid) begin
        crc_run_reg     <= crc_next;
        pix_cnt_run_reg <= pix_cnt_run_reg + 17'd1;
      end

      // Timeout outranks everything; it also forgets the last edge so the
      // first edge after sync returns is not length-checked.
      if (timeout) begin
        state_reg     <= ST_HUNT;
        sync_err_reg  <= 1'b1;
        have_edge_reg <= 1'b0;
      end else if (frame_start) begin
        case (state_reg)
          ST_HUNT:    state_reg <= ST_ACQUIRE;
          ST_ACQUIRE: if (count_ok) state_reg <= ST_LOCKED;
          ST_LOCKED: begin
            if (count_ok) begin
              frame_done_reg <= 1'b1;
              frame_crc_reg  <= crc_run_reg;
              pix_count_reg  <= pix_cnt_run_reg;
            end else begin
              state_reg    <= ST_ACQUIRE;
              sync_err_reg <= 1'b1;
            end
          end
          default:    state_reg <= ST_HUNT;
        endcase
      end else if (width_err || len_err) begin
        sync_err_reg <= 1'b1;
        if (state_reg == ST_LOCKED) state_reg <= ST_ACQUIRE;
      end
    end
  end

  assign PIX_X      = line_cnt_reg[10:2];
  assign PIX_Y      = pix_y_reg;
  assign PIX_VALID  = pix_valid;
  assign FRAME_DONE = frame_done_reg;
  assign FRAME_CRC  = frame_crc_reg;
  assign PIX_COUNT  = pix_count_reg;
  assign LOCKED     = state_reg == ST_LOCKED;
  assign SYNC_ERR   = sync_err_reg;

endmodule

// File: tb/tb_tb_video_monitor.sv
// Directed bench for tb_video_monitor, run with a scaled-down raster
// (64-clock lines, 20-line frames) so whole frames stay short.
module tb_tb_video_monitor;

  localparam int L_CLKS  = 64;
  localparam int L_TOL   = 4;
  localparam int H_MAX   = 8;
  localparam int V_MIN   = 32;
  localparam int N_LINES = 20;
  localparam int AX0     = 2;
  localparam int AW      = 10;
  localparam int AY0     = 4;
  localparam int AH      = 12;
  localparam int V_LINES = 3;
  localparam int V_LOW   = 48;
  localparam int H_LOW   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync;
  logic [6:0]  vr, vg, vb;
  logic [8:0]  pix_x, pix_y;
  logic        pix_valid, frame_done, locked, sync_err;
  logic [15:0] frame_crc;
  logic [16:0] pix_count;

  logic [20:0] crc_d;
  logic [15:0] crc_i, crc_o;

  int n_cmp = 0;
  int n_bad = 0;
  int fd_cnt = 0;
  int se_cnt = 0;
  int grad = 0;

  always #5 clk = ~clk;

  tb_video_monitor #(
    .LINE_CLKS(L_CLKS), .LINE_TOL(L_TOL), .HSYNC_MAX(H_MAX), .VSYNC_MIN(V_MIN),
    .LINES(N_LINES), .ACT_X0(AX0), .ACT_W(AW), .ACT_Y0(AY0), .ACT_H(AH)
  ) dut (
    .CLK_24M    (clk),
    .RESET      (rst),
    .VIDEO_SYNC (vsync),
    .VIDEO_R    (vr),
    .VIDEO_G    (vg),
    .VIDEO_B    (vb),
    .PIX_X      (pix_x),
    .PIX_Y      (pix_y),
    .PIX_VALID  (pix_valid),
    .FRAME_DONE (frame_done),
    .FRAME_CRC  (frame_crc),
    .PIX_COUNT  (pix_count),
    .LOCKED     (locked),
    .SYNC_ERR   (sync_err)
  );

  crc16_ccitt_w21 u_crc_alone (
    .data    (crc_d),
    .crc_in  (crc_i),
    .crc_out (crc_o)
  );

  always @(negedge clk) begin
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (sync_err)   se_cnt <= se_cnt + 1;
  end

  typedef struct {
    logic [20:0] d;
    logic [15:0] ci;
    logic [15:0] co;
  } crc_vec_t;

  typedef struct {
    int len;
    int low;
    int err;
  } line_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Shift-register form of the CCITT polynomial: taps into bits 12, 5, 0.
  function automatic logic [15:0] model_step(input logic [15:0] c, input logic [20:0] d);
    logic [15:0] s;
    logic        fb;
    s = c;
    for (int i = 20; i >= 0; i--) begin
      fb = s[15] ^ d[i];
      s  = {s[14:12], s[11] ^ fb, s[10:5], s[4] ^ fb, s[3:0], fb};
    end
    return s;
  endfunction

  function automatic logic [15:0] model_frame(input int gr);
    logic [15:0] c;
    logic [20:0] d;
    c = 16'hFFFF;
    for (int y = AY0; y < AY0 + AH; y++) begin
      for (int x = AX0; x < AX0 + AW; x++) begin
        d = (gr != 0) ? {7'(x), 7'(y), 7'h00} : {7'h7F, 7'h7F, 7'h7F};
        c = model_step(c, d);
      end
    end
    return c;
  endfunction

  // Cycle c of a line is sampled while the DUT line counter reads c-1.
  task automatic drive_line(input int len, input int low, input int y);
    for (int c = 0; c < len; c++) begin
      vsync = (c < low) ? 1'b0 : 1'b1;
      if (grad != 0) begin
        vr = (c == 0) ? 7'h00 : 7'((c - 1) / 4);
        vg = 7'(y);
        vb = 7'h00;
      end else begin
        vr = 7'h7F; vg = 7'h7F; vb = 7'h7F;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_lines(input int y0, input int y1);
    for (int y = y0; y < y1; y++) begin
      drive_line(L_CLKS, (y < V_LINES) ? V_LOW : H_LOW, y);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pix_x"}, 32'(pix_x), 32'd0);
    check({tag, "_pix_y"}, 32'(pix_y), 32'd0);
    check({tag, "_crc"}, 32'(frame_crc), 32'd0);
    check({tag, "_count"}, 32'(pix_count), 32'd0);
    check({tag, "_strobes"}, {28'd0, pix_valid, frame_done, locked, sync_err}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    crc_vec_t  ctbl[5];
    line_vec_t ftbl[10];
    logic [15:0] rnd_c;
    logic [20:0] rnd_d;
    int se0, fd0, first_err, pv_after;

    ctbl[0] = '{21'h000000, 16'h0000, 16'h0000};
    ctbl[1] = '{21'h000001, 16'h0000, 16'h1021};
    ctbl[2] = '{21'h000002, 16'h0000, 16'h2042};
    ctbl[3] = '{21'h000000, 16'h0001, 16'h2462};
    ctbl[4] = '{21'h000001, 16'h0001, 16'h3443};

    ftbl[0] = '{L_CLKS, 20, 1};
    ftbl[1] = '{L_CLKS, H_MAX, 1};
    ftbl[2] = '{L_CLKS, H_MAX - 1, 0};
    ftbl[3] = '{L_CLKS, V_MIN - 1, 1};
    ftbl[4] = '{L_CLKS + 8, H_LOW, 1};
    ftbl[5] = '{L_CLKS + 3, H_LOW, 0};
    ftbl[6] = '{L_CLKS + L_TOL, H_LOW, 0};
    ftbl[7] = '{L_CLKS + L_TOL + 1, H_LOW, 1};
    ftbl[8] = '{L_CLKS - L_TOL, H_LOW, 0};
    ftbl[9] = '{L_CLKS - L_TOL - 1, H_LOW, 1};

    rst = 1'b1; vsync = 1'b1; vr = '0; vg = '0; vb = '0;
    crc_d = '0; crc_i = '0;

    for (int i = 0; i < 5; i++) begin
      crc_d = ctbl[i].d; crc_i = ctbl[i].ci; #1;
      check($sformatf("crc_vec%0d", i), 32'(crc_o), 32'(ctbl[i].co));
    end
    for (int i = 0; i < 6; i++) begin
      rnd_d = 21'($urandom); rnd_c = 16'($urandom);
      crc_d = rnd_d; crc_i = rnd_c; #1;
      check($sformatf("crc_rand%0d", i), 32'(crc_o), 32'(model_step(rnd_c, rnd_d)));
    end

    repeat (3) @(posedge clk); #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Nominal frames: lock at frame 2 start, first FRAME_DONE at frame 3 start.
    drive_lines(0, N_LINES);
    check("acquire_after_f1", 32'(locked), 32'd0);
    drive_lines(0, 1);
    check("locked_at_f2", 32'(locked), 32'd1);
    check("pix_y_frame_start", 32'(pix_y), 32'd0);
    check("no_done_at_f2", 32'(fd_cnt), 32'd0);
    drive_lines(1, N_LINES);
    drive_lines(0, 1);
    check("done_at_f3", 32'(fd_cnt), 32'd1);
    check("count_const", 32'(pix_count), 32'(AW * AH));
    check("crc_const", 32'(frame_crc), 32'(model_frame(0)));
    check("no_err_nominal", 32'(se_cnt), 32'd0);

    // Gradient frames, two in a row.
    grad = 1;
    for (int f = 0; f < 2; f++) begin
      drive_lines(1, N_LINES);
      drive_lines(0, 1);
      check($sformatf("grad_done%0d", f), 32'(fd_cnt), 32'(2 + f));
      check($sformatf("grad_crc%0d", f), 32'(frame_crc), 32'(model_frame(1)));
      check($sformatf("grad_count%0d", f), 32'(pix_count), 32'(AW * AH));
    end

    // Short frame while locked.
    se0 = se_cnt; fd0 = fd_cnt;
    drive_lines(1, N_LINES - 1);
    drive_lines(0, 1);
    check("short_frame_err", 32'(se_cnt - se0), 32'd1);
    check("short_frame_unlock", 32'(locked), 32'd0);
    check("short_frame_no_done", 32'(fd_cnt - fd0), 32'd0);
    drive_lines(1, N_LINES);
    drive_lines(0, 1);
    check("relock_after_short", 32'(locked), 32'd1);
    check("relock_no_done", 32'(fd_cnt - fd0), 32'd0);

    // Line timing faults: good line, test line, good line whose fall checks it.
    for (int i = 0; i < 10; i++) begin
      se0 = se_cnt;
      drive_line(L_CLKS, H_LOW, 50);
      drive_line(ftbl[i].len, ftbl[i].low, 50);
      drive_line(L_CLKS, H_LOW, 50);
      check($sformatf("fault_len%0d_low%0d", ftbl[i].len, ftbl[i].low),
            32'(se_cnt - se0), 32'(ftbl[i].err));
    end
    check("unlocked_after_faults", 32'(locked), 32'd0);

    // Sync loss while locked.
    drive_lines(0, N_LINES);
    drive_lines(0, 1);
    check("locked_before_loss", 32'(locked), 32'd1);
    drive_lines(1, 6);
    se0 = se_cnt; first_err = -1; pv_after = 0;
    vsync = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (k == H_LOW - 1) vsync = 1'b1;
      if (k == 0) check("pix_x_after_fall", 32'(pix_x), 32'd0);
      if (k == 7) check("pix_x_phase_wrap", 32'(pix_x), 32'd1);
      if (sync_err && first_err < 0) first_err = k;
      if (first_err >= 0 && pix_valid) pv_after++;
    end
    check("loss_err_clock", 32'(first_err), 32'(L_CLKS + L_TOL + 1));
    check("loss_err_once", 32'(se_cnt - se0), 32'd1);
    check("loss_unlocked", 32'(locked), 32'd0);
    check("loss_no_pix_valid", 32'(pv_after), 32'd0);

    // Asynchronous reset mid-frame while locked.
    drive_lines(0, N_LINES);
    drive_lines(0, 1);
    drive_lines(1, 10);
    check("locked_before_reset", 32'(locked), 32'd1);
    fd0 = fd_cnt;
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive_lines(10, N_LINES);
    drive_lines(0, 1);
    check("rst_acquire", 32'(locked), 32'd0);
    drive_lines(1, N_LINES);
    drive_lines(0, 1);
    check("rst_relock", 32'(locked), 32'd1);
    check("rst_no_early_done", 32'(fd_cnt - fd0), 32'd0);
    drive_lines(1, N_LINES);
    drive_lines(0, 1);
    check("rst_first_done", 32'(fd_cnt - fd0), 32'd1);
    check("rst_crc", 32'(frame_crc), 32'(model_frame(1)));
    check("rst_count", 32'(pix_count), 32'(AW * AH));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
